// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : ALUFun codes, MIPS opcode/funct constants, decoded-op record    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int INSTR_W  = 32;
    localparam int ALUFUN_W = 6;
    localparam int SHAMT_W  = 5;
    localparam int IMM_W    = 32;

    localparam logic [ALUFUN_W-1:0] ALU_ADD   = 6'b000000;
    localparam logic [ALUFUN_W-1:0] ALU_SUB   = 6'b000001;
    localparam logic [ALUFUN_W-1:0] ALU_AND   = 6'b011000;
    localparam logic [ALUFUN_W-1:0] ALU_OR    = 6'b011110;
    localparam logic [ALUFUN_W-1:0] ALU_XOR   = 6'b010110;
    localparam logic [ALUFUN_W-1:0] ALU_NOR   = 6'b010001;
    localparam logic [ALUFUN_W-1:0] ALU_PASSA = 6'b011010;
    localparam logic [ALUFUN_W-1:0] ALU_SLL   = 6'b100000;
    localparam logic [ALUFUN_W-1:0] ALU_SRL   = 6'b100001;
    localparam logic [ALUFUN_W-1:0] ALU_SRA   = 6'b100011;
    localparam logic [ALUFUN_W-1:0] ALU_EQ    = 6'b110011;
    localparam logic [ALUFUN_W-1:0] ALU_NEQ   = 6'b110001;
    localparam logic [ALUFUN_W-1:0] ALU_LT    = 6'b110101;
    localparam logic [ALUFUN_W-1:0] ALU_LEZ   = 6'b111101;
    localparam logic [ALUFUN_W-1:0] ALU_LTZ   = 6'b111011;
    localparam logic [ALUFUN_W-1:0] ALU_GTZ   = 6'b111111;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [ALUFUN_W-1:0] alufun;
        logic                sign;
        logic                asel;
        logic                bsel;
        logic [SHAMT_W-1:0]  shamt;
        logic [IMM_W-1:0]    imm;
        logic                illegal;
    } op_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_issue_if : fetch-side instruction and execute-side ALU op channels |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface alu_op_issue_if
    import alu_pkg::*;
();
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [ALUFUN_W-1:0] out_alufun;
    logic                out_sign;
    logic                out_asel;
    logic                out_bsel;
    logic [SHAMT_W-1:0]  out_shamt;
    logic [IMM_W-1:0]    out_imm;
    logic                out_illegal;

    // The issue block itself
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alufun, out_sign, out_asel,
               out_bsel, out_shamt, out_imm, out_illegal
    );

    // Fetch/execute side environment
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alufun, out_sign, out_asel,
               out_bsel, out_shamt, out_imm, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_decode : combinational MIPS instruction to ALU operation decoder   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [ALUFUN_W-1:0] alufun,
    output logic                sign,
    output logic                asel,
    output logic                bsel,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [IMM_W-1:0]    imm,
    output logic                illegal
);
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_rt;
    logic [IMM_W-1:0] w_sext;
    logic [IMM_W-1:0] w_zext;
    logic             w_unused_rs;

    assign w_op        = instr[31:26];
    assign w_funct     = instr[5:0];
    assign w_rt        = instr[20:16];
    assign w_sext      = {{16{instr[15]}}, instr[15:0]};
    assign w_zext      = {16'h0000, instr[15:0]};
    assign w_unused_rs = ^instr[25:21];

    always_comb begin
        alufun  = ALU_ADD;
        sign    = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        shamt   = '0;
        imm     = '0;
        illegal = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD:  begin alufun = ALU_ADD; sign = 1'b1; end
                    FN_ADDU: alufun = ALU_ADD;
                    FN_SUB:  begin alufun = ALU_SUB; sign = 1'b1; end
                    FN_SUBU: alufun = ALU_SUB;
                    FN_AND:  alufun = ALU_AND;
                    FN_OR:   alufun = ALU_OR;
                    FN_XOR:  alufun = ALU_XOR;
                    FN_NOR:  alufun = ALU_NOR;
                    FN_SLT:  begin alufun = ALU_LT; sign = 1'b1; end
                    FN_SLTU: alufun = ALU_LT;
                    FN_SLL:  begin alufun = ALU_SLL; asel = 1'b1; shamt = instr[10:6]; end
                    FN_SRL:  begin alufun = ALU_SRL; asel = 1'b1; shamt = instr[10:6]; end
                    FN_SRA:  begin alufun = ALU_SRA; asel = 1'b1; shamt = instr[10:6]; end
                    FN_JR:   alufun = ALU_ADD;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin alufun = ALU_ADD; sign = 1'b1; bsel = 1'b1; imm = w_sext; end
            OP_ADDIU: begin alufun = ALU_ADD; bsel = 1'b1; imm = w_sext; end
            OP_SLTI:  begin alufun = ALU_LT; sign = 1'b1; bsel = 1'b1; imm = w_sext; end
            OP_SLTIU: begin alufun = ALU_LT; bsel = 1'b1; imm = w_sext; end
            OP_ANDI:  begin alufun = ALU_AND; bsel = 1'b1; imm = w_zext; end
            OP_ORI:   begin alufun = ALU_OR; bsel = 1'b1; imm = w_zext; end
            // lui is realised as the 16-bit immediate shifted left by 16
            OP_LUI: begin
                alufun = ALU_SLL;
                asel   = 1'b1;
                bsel   = 1'b1;
                shamt  = 5'd16;
                imm    = w_zext;
            end
            OP_LW, OP_SW: begin alufun = ALU_ADD; bsel = 1'b1; imm = w_sext; end
            OP_BEQ:  begin alufun = ALU_EQ;  sign = 1'b1; end
            OP_BNE:  begin alufun = ALU_NEQ; sign = 1'b1; end
            OP_BLEZ: begin alufun = ALU_LEZ; sign = 1'b1; end
            OP_BGTZ: begin alufun = ALU_GTZ; sign = 1'b1; end
            OP_REGIMM: begin
                if (w_rt == 5'd0) begin
                    alufun = ALU_LTZ;
                    sign   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J, OP_JAL: alufun = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_op_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_issue : decodes fetched instructions into ALU ops via a 2-entry    |
// |                registered skid buffer; counts illegal instructions        |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    alu_op_issue_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    op_t              w_dec;
    op_t              r_main;
    op_t              r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_take;
    logic             w_skid_capture;
    logic             w_skid_valid_nxt;

    alu_op_decode u_decode (
        .instr   (bus.in_instr),
        .alufun  (w_dec.alufun),
        .sign    (w_dec.sign),
        .asel    (w_dec.asel),
        .bsel    (w_dec.bsel),
        .shamt   (w_dec.shamt),
        .imm     (w_dec.imm),
        .illegal (w_dec.illegal)
    );

    assign w_in_fire      = bus.in_valid & r_in_ready;
    assign w_out_fire     = r_main_valid & bus.out_ready;
    assign w_main_take    = ~r_main_valid | w_out_fire;
    assign w_skid_capture = w_in_fire & r_main_valid & ~w_out_fire;

    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (w_skid_capture) begin
            w_skid_valid_nxt = 1'b1;
        end else if (w_main_take) begin
            w_skid_valid_nxt = 1'b0;
        end
    end

    // in_ready is registered from the next skid state, so out_ready never
    // reaches the fetch side combinationally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_main       <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_main_take) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                end else if (w_in_fire) begin
                    r_main       <= w_dec;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end
            if (w_skid_capture) begin
                r_skid <= w_dec;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!flush && w_in_fire && w_dec.illegal && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.out_alufun  = r_main.alufun;
    assign bus.out_sign    = r_main.sign;
    assign bus.out_asel    = r_main.asel;
    assign bus.out_bsel    = r_main.bsel;
    assign bus.out_shamt   = r_main.shamt;
    assign bus.out_imm     = r_main.imm;
    assign bus.out_illegal = r_main.illegal;
    assign illegal_cnt     = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_alu_op_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_op_issue : directed self-checking bench for alu_op_issue           |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_alu_op_issue;
    import alu_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [CNT_W-1:0] illegal_cnt;
    int               n_checks;
    int               n_errors;

    alu_op_issue_if bus ();

    alu_op_issue #(.CNT_W(CNT_W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus.slave),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for a single cycle; afterwards the DUT shows it (out_ready=1)
    task automatic send(input logic [31:0] instr);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cnt", 32'(illegal_cnt), 32'd0);
        check("rst_alufun", 32'(bus.out_alufun), 32'd0);
        check("rst_imm", bus.out_imm, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // add $3,$1,$2
        send(32'h00221820);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_alufun", 32'(bus.out_alufun), 32'h00);
        check("add_sign", 32'(bus.out_sign), 32'd1);
        check("add_asel", 32'(bus.out_asel), 32'd0);
        check("add_bsel", 32'(bus.out_bsel), 32'd0);
        check("add_illegal", 32'(bus.out_illegal), 32'd0);

        send(32'h3C011234);
        check("lui_alufun", 32'(bus.out_alufun), 32'h20);
        check("lui_asel", 32'(bus.out_asel), 32'd1);
        check("lui_shamt", 32'(bus.out_shamt), 32'd16);
        check("lui_bsel", 32'(bus.out_bsel), 32'd1);
        check("lui_imm", bus.out_imm, 32'h00001234);

        send(32'h00011083);
        check("sra_alufun", 32'(bus.out_alufun), 32'h23);
        check("sra_shamt", 32'(bus.out_shamt), 32'd2);
        check("sra_asel", 32'(bus.out_asel), 32'd1);

        send(32'h2421FFFF);
        check("addiu_alufun", 32'(bus.out_alufun), 32'h00);
        check("addiu_sign", 32'(bus.out_sign), 32'd0);
        check("addiu_imm", bus.out_imm, 32'hFFFFFFFF);
        check("addiu_shamt", 32'(bus.out_shamt), 32'd0);

        send(32'h3021FFFF);
        check("andi_alufun", 32'(bus.out_alufun), 32'h18);
        check("andi_imm", bus.out_imm, 32'h0000FFFF);

        send(32'h04200003);
        check("bltz_alufun", 32'(bus.out_alufun), 32'h3B);
        check("bltz_bsel", 32'(bus.out_bsel), 32'd0);
        check("bltz_sign", 32'(bus.out_sign), 32'd1);

        send(32'h0022182A);
        check("slt_alufun", 32'(bus.out_alufun), 32'h35);
        check("slt_sign", 32'(bus.out_sign), 32'd1);

        send(32'h10220003);
        check("beq_alufun", 32'(bus.out_alufun), 32'h33);

        // Illegal words bump the counter
        send(32'hFC000000);
        check("ill_flag", 32'(bus.out_illegal), 32'd1);
        check("ill_alufun", 32'(bus.out_alufun), 32'h00);
        check("ill_cnt1", 32'(illegal_cnt), 32'd1);
        send(32'h00000001);
        check("ill_rfunct", 32'(bus.out_illegal), 32'd1);
        send(32'h04210003);
        check("ill_regimm", 32'(bus.out_illegal), 32'd1);
        check("ill_cnt3", 32'(illegal_cnt), 32'd3);
        tick();
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: word1 main, word2 skid, word3 held
        bus.out_ready = 1'b0;
        send(32'h00221820);
        check("bp_in_ready1", 32'(bus.in_ready), 32'd1);
        send(32'h00221822);
        check("bp_in_ready0", 32'(bus.in_ready), 32'd0);
        check("bp_w1_alufun", 32'(bus.out_alufun), 32'h00);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00221824;
        tick();
        check("bp_hold_alufun", 32'(bus.out_alufun), 32'h00);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_w2_alufun", 32'(bus.out_alufun), 32'h01);
        check("bp_w2_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_w3_alufun", 32'(bus.out_alufun), 32'h18);
        check("bp_w3_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // Flush with both entries full, then a flushed illegal word
        bus.out_ready = 1'b0;
        send(32'h00221820);
        send(32'h00221822);
        check("fl_full_ready", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        tick();
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFC000000;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("fl_cnt_kept", 32'(illegal_cnt), 32'd3);
        check("fl_word_dropped", 32'(bus.out_valid), 32'd0);
        tick();
        check("fl_no_output", 32'(bus.out_valid), 32'd0);

        // Saturation: 300 back-to-back illegals starting from 3
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFC000000;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 251) check("sat_254", 32'(illegal_cnt), 32'd254);
            if (i == 252) check("sat_255", 32'(illegal_cnt), 32'd255);
        end
        bus.in_valid = 1'b0;
        check("sat_final", 32'(illegal_cnt), 32'd255);

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        send(32'h3C011234);
        send(32'h00221822);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_imm", bus.out_imm, 32'd0);
        check("arst_alufun", 32'(bus.out_alufun), 32'd0);
        check("arst_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_no_output", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Instruction-side producer of the ALU operation interface (ALUFun[5:0], Sign) in the single-cycle/pipelined MIPS core.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake and decodes them into ALUFun, Sign, operand selects, shift amount and extended immediate.
- Presents the result to the execute stage through a registered 2-entry skid buffer, which gives full throughput under backpressure.
- Also counts illegal instructions.

Parameters:
CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush (branch/exception)
in_valid  in  1  instruction word valid
in_ready  out  1  block can accept instruction
in_instr  in  32  MIPS instruction word
out_valid  out  1  decoded op valid
out_ready  in  1  execute stage accepts op
out_alufun  out  6  ALUFun code
out_sign  out  1  signed-compare/overflow select
out_asel  out  1  0: A=rs, 1: A=shamt
out_bsel  out  1  0: B=rt, 1: B=out_imm
out_shamt  out  5  shift amount
out_imm  out  32  extended immediate
out_illegal  out  1  op was undecodable
illegal_cnt  out  CNT_W  saturating count of accepted illegal ops

Behaviour:
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- R-type (op 0x00), asel=0, bsel=0:
  - funct 20/21 ADD, sign 1/0
  - funct 22/23 SUB, sign 1/0
  - 24 AND; 25 OR; 26 XOR; 27 NOR
  - 2A/2B LT, sign 1/0
  - 00/02/03 SLL/SRL/SRA with asel=1, shamt=instr[10:6]
  - 08 (jr) ADD
  - any other funct: illegal
- I-type, bsel=1:
  - 08/09 ADD, sign 1/0, imm sign-extended
  - 0A/0B LT, sign 1/0, imm sign-extended
  - 0C AND, 0D OR, imm zero-extended
  - 0F lui: SLL, asel=1, shamt=16, imm zero-extended
  - 23 lw / 2B sw: ADD, sign 0, imm sign-extended
- Branches, bsel=0, sign=1:
  - 04 EQ; 05 NEQ; 06 LEZ; 07 GTZ
  - 01 with rt=0: LTZ; 01 with rt≠0: illegal
- 02/03 (j/jal): ADD, no operand effect.
- Illegal: alufun=ADD, sign=0, selects 0, out_illegal=1.
- Unused fields are 0: sign=0 for logic/shift ops; shamt=0 unless a shift op.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
- Output register (main) update when main is empty or out_fire:
  - skid valid: main loads skid, skid clears;
  - else in_fire: main loads decoded input;
  - else main valid clears.
- Skid update: in_fire while main is valid and not out_fire: skid captures decoded input.
- Latency: instruction accepted at edge N appears on out_* after edge N (one cycle). Throughput is 1 op/cycle while out_ready=1.
- Ordering: strict FIFO; no drop, no duplication.
- Payload is stable while out_valid=1 and out_ready=0.
- flush:
  - Overrides everything. Next edge clears main and skid valid.
  - A word offered in the flush cycle is discarded.
  - illegal_cnt is not changed by a flushed word.
- illegal_cnt increments when an illegal op is accepted (in_fire, no flush) and saturates at 2^CNT_W-1.
- Reset (asynchronous assert, synchronous deassert expected upstream): out_valid=0, skid empty, in_ready=1, all out_* payload=0, illegal_cnt=0. Reset mid-transfer drops everything in flight.

Decomposition:
- Package alu_pkg holds:
  - ALUFun localparams, as listed above;
  - opcode and funct constants;
  - the decoded-op record field widths.
- One combinational sub-module, alu_op_decode (instr → alufun, sign, asel, bsel, shamt, imm, illegal), instantiated once on the input path.
- Top holds the skid buffer and counter.

Test Plan:
- add 0x00221820, out_ready=1 → next cycle out_valid=1, alufun 000000, sign 1, asel 0, bsel 0, illegal 0.
- lui 0x3C011234 → alufun 100000, asel 1, shamt 16, bsel 1, imm 0x00001234. sra 0x00011083 → 100011, shamt 2.
- addiu 0x2421FFFF → ADD, sign 0, imm 0xFFFFFFFF. andi 0x3021FFFF → AND, imm 0x0000FFFF. bltz 0x04200003 → 111011, bsel 0.
- Backpressure: out_ready=0, stream 3 words → word1 in main, word2 in skid, in_ready=0 the following cycle, word3 held. Raise out_ready → outputs word1, word2, word3 on consecutive cycles, in order.
- Illegal 0xFC000000 → illegal 1, alufun 000000, illegal_cnt 1. 300 consecutive illegals → illegal_cnt saturates at 255.
- Fill both entries then flush=1 → next cycle out_valid 0, in_ready 1, no further outputs. Assert reset asynchronously mid-stream → outputs zero immediately, in_ready 1 after release.
